// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: walks one lw/sw through decode, address generation,
// a req/ack memory transaction and register write-back, then pulses done or error.
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instruction,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              error
);

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_base;
    logic [DATA_W-1:0] r_sdata;
    logic [DATA_W-1:0] r_ldata;
    logic [DATA_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;

    logic [5:0]  w_op;
    logic [4:0]  w_rt;
    logic [15:0] w_imm;
    logic        w_is_sw;
    logic        w_is_mem;

    assign w_op     = r_instr[31:26];
    assign w_rt     = r_instr[20:16];
    assign w_imm    = r_instr[15:0];
    assign w_is_sw  = (w_op == OP_SW);
    assign w_is_mem = (w_op == OP_LW) || w_is_sw;

    assign rf_raddr1   = r_instr[25:21];
    assign rf_raddr2   = w_rt;
    assign rf_waddr    = w_rt;
    assign rf_wdata    = r_ldata;
    assign alu_a       = r_base;
    assign alu_b       = {{(DATA_W-16){w_imm[15]}}, w_imm};
    assign alu_control = 3'b010;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_sdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        rf_we       = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = reset;
                if (instr_valid) w_next = S_DECODE;
            end
            S_DECODE: w_next = w_is_mem ? S_EXEC : S_ERR;
            S_EXEC:   w_next = (alu_result[1:0] != 2'b00) ? S_ERR : S_MEM;
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_sw;
                // The count indexes the current MEM cycle, so the last one is TIMEOUT-1.
                if (mem_ack)                w_next = w_is_sw ? S_DONE : S_WB;
                else if (r_cnt == CNT_LAST) w_next = S_ERR;
            end
            S_WB: begin
                rf_we  = (w_rt != 5'd0);
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                error  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr <= '0;
            r_base  <= '0;
            r_sdata <= '0;
            r_ldata <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE:   if (instr_valid) r_instr <= instruction;
                S_DECODE: begin
                    r_base <= rf_rdata1;
                    if (w_is_sw) r_sdata <= rf_rdata2;
                end
                S_EXEC: begin
                    r_addr <= alu_result;
                    r_cnt  <= '0;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (!w_is_sw) r_ldata <= mem_rdata;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
